// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite bus bundle between the team's master/interconnect and one slave-select target.
interface ahb_slave_mem_if;
  localparam int unsigned ADDR_BUS_W = 32;
  localparam int unsigned DATA_BUS_W = 32;

  logic                  hsel;
  logic [ADDR_BUS_W-1:0] haddr;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [3:0]            hprot;
  logic [1:0]            htrans;
  logic                  hmastlock;
  logic                  hready;
  logic [DATA_BUS_W-1:0] hwdata;
  logic                  hreadyout;
  logic                  hresp;
  logic [DATA_BUS_W-1:0] hrdata;

  modport master (
    output hsel, haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hready, hwdata,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hready, hwdata,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave backed by a word-addressed register-file memory with two-cycle ERROR responses.
// Optional data-phase wait states are enabled by defining AHB_SLAVE_WAIT_EN.
module ahb_slave_mem #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            hclk,
  input  logic            hreset,
  ahb_slave_mem_if.slave  bus
);
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = DATA_W / 8;

`ifdef AHB_SLAVE_WAIT_EN
  typedef enum logic [2:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2, ST_WAIT} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;
`endif

  state_t              state, state_next;
  logic                ready_q, resp_q, ready_next, resp_next;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                pend_write;
  logic [ADDR_W-1:0]   pend_idx;
  logic [LANES-1:0]    pend_lanes;
  logic                accept, addr_err, commit, fwd;
  logic [ADDR_W-1:0]   idx;
  logic [LANES-1:0]    lanes;
  logic [DATA_W-1:0]   merged;
  state_t              ok_state;
  logic                wait_done;
  logic                unused_bits;

  assign bus.hreadyout = ready_q;
  assign bus.hresp     = resp_q;
  assign bus.hrdata    = rdata_q;

  // A new address phase is only taken while this slave is not stretching its own data phase
  assign accept = bus.hsel && bus.hready && bus.htrans[1] && ready_q;
  assign idx    = bus.haddr[ADDR_W+1:2];
  assign commit = pend_write && (state == ST_DATA);
  assign fwd    = commit && (pend_idx == idx);

  // Size, alignment and out-of-range decode of the address phase
  always_comb begin
    addr_err = 1'b0;
    if (bus.hsize > 3'd2)                                  addr_err = 1'b1;
    else if ((bus.hsize == 3'd1) && bus.haddr[0])          addr_err = 1'b1;
    else if ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00)) addr_err = 1'b1;
    if ((bus.haddr >> (ADDR_W + 2)) != 32'd0)              addr_err = 1'b1;
  end

  // Little-endian byte-lane enables
  always_comb begin
    case (bus.hsize)
      3'd0:    lanes = 4'b0001 << bus.haddr[1:0];
      3'd1:    lanes = bus.haddr[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
  end

  // Word as it will look after the pending write commits
  always_comb begin
    merged = mem[pend_idx];
    for (int b = 0; b < int'(LANES); b++) begin
      if (pend_lanes[b]) merged[8*b +: 8] = bus.hwdata[8*b +: 8];
    end
  end

`ifdef AHB_SLAVE_WAIT_EN
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  logic [CNT_W-1:0] wait_cnt;

  assign ok_state    = (WAIT_CYCLES == 0) ? ST_DATA : ST_WAIT;
  assign wait_done   = (32'(wait_cnt) + 32'd1) >= WAIT_CYCLES;
  assign unused_bits = ^{bus.hburst, bus.hprot, bus.hmastlock};

  always_ff @(posedge hclk) begin
    if (hreset || (state != ST_WAIT)) wait_cnt <= '0;
    else                              wait_cnt <= wait_cnt + CNT_W'(1);
  end
`else
  assign ok_state    = ST_DATA;
  assign wait_done   = 1'b1;
  assign unused_bits = ^{bus.hburst, bus.hprot, bus.hmastlock, WAIT_CYCLES, wait_done};
`endif

  always_comb begin
    state_next = state;
    ready_next = 1'b1;
    resp_next  = 1'b0;
    case (state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (!accept)      state_next = ST_IDLE;
        else if (addr_err) state_next = ST_ERR1;
        else              state_next = ok_state;
      end
      ST_ERR1: state_next = ST_ERR2;
`ifdef AHB_SLAVE_WAIT_EN
      ST_WAIT: if (wait_done) state_next = ST_DATA;
`endif
      default: state_next = ST_IDLE;
    endcase
    case (state_next)
      ST_ERR1: begin ready_next = 1'b0; resp_next = 1'b1; end
      ST_ERR2: resp_next = 1'b1;
`ifdef AHB_SLAVE_WAIT_EN
      ST_WAIT: ready_next = 1'b0;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state   <= ST_IDLE;
      ready_q <= 1'b1;
      resp_q  <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= ready_next;
      resp_q  <= resp_next;
    end
  end

  // Memory, pending write and read data; a read hitting the committing word gets the merged value
  always_ff @(posedge hclk) begin
    if (hreset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      pend_write <= 1'b0;
      pend_idx   <= '0;
      pend_lanes <= '0;
      rdata_q    <= '0;
    end else begin
      if (commit) mem[pend_idx] <= merged;
      if (ready_q) pend_write <= accept && !addr_err && bus.hwrite;
      if (accept) begin
        pend_idx   <= idx;
        pend_lanes <= lanes;
      end
      if (accept && !addr_err && !bus.hwrite) rdata_q <= fwd ? merged : mem[idx];
    end
  end
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: vector table of single transfers plus pipelined/reset sequences.
// Works in both builds; define AHB_SLAVE_WAIT_EN for the wait-state variant.
module tb_ahb_slave_mem;
`ifdef AHB_SLAVE_WAIT_EN
  localparam int WAIT_EXP = 2;
`else
  localparam int WAIT_EXP = 0;
`endif
  localparam int LIMIT = 20;

  logic hclk = 1'b0;
  logic hreset;
  int   checks = 0;
  int   errors = 0;

  ahb_slave_mem_if bus();
  assign bus.hready = bus.hreadyout;

  ahb_slave_mem #(.ADDR_W(4), .WAIT_CYCLES(2)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    string       name;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic        chk;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic w, input logic [2:0] s, input logic [31:0] a,
                     input logic [31:0] d, input logic e, input logic c, input logic [31:0] r);
    vec_t v;
    v.name = n; v.wr = w; v.sz = s; v.addr = a; v.wdata = d; v.err = e; v.chk = c; v.rdata = r;
    vecs.push_back(v);
  endtask

  task automatic idle_bus();
    bus.hsel   = 1'b0;
    bus.htrans = 2'b00;
  endtask

  // Present a NONSEQ address phase and hold it until an edge with hready=1 takes it
  task automatic issue(input string name, input logic wr, input logic [2:0] sz, input logic [31:0] a);
    int   n;
    logic acc;
    bus.hsel = 1'b1; bus.hwrite = wr; bus.hsize = sz; bus.haddr = a; bus.htrans = 2'b10;
    n = 0;
    do begin
      acc = bus.hready;
      @(posedge hclk); #1;
      n++;
    end while (!acc && n < LIMIT);
    if (!acc) begin
      errors++;
      $display("FAIL %s_accept: address phase not taken within %0d cycles", name, LIMIT);
    end
  endtask

  // Run the data phase just opened by issue(), checking response, wait count and read data
  task automatic data_phase(input string name, input logic [31:0] wdata, input logic err,
                            input logic chk_rd, input logic [31:0] exp_rd);
    int waits;
    idle_bus();
    bus.hwdata = wdata;
    if (err) begin
      chk({name, "_err1_ready"}, 32'(bus.hreadyout), 32'd0);
      chk({name, "_err1_resp"},  32'(bus.hresp),     32'd1);
      @(posedge hclk); #1;
      chk({name, "_err2_ready"}, 32'(bus.hreadyout), 32'd1);
      chk({name, "_err2_resp"},  32'(bus.hresp),     32'd1);
    end else begin
      waits = 0;
      while (!bus.hreadyout && waits < LIMIT) begin
        @(posedge hclk); #1;
        waits++;
      end
      chk({name, "_waits"}, 32'(waits), 32'(WAIT_EXP));
      chk({name, "_resp"},  32'(bus.hresp), 32'd0);
    end
    if (chk_rd) chk({name, "_rdata"}, bus.hrdata, exp_rd);
    @(posedge hclk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    hreset = 1'b1;
    bus.hsel = 1'b0; bus.haddr = '0; bus.hwrite = 1'b0; bus.hsize = 3'd2;
    bus.hburst = 3'd0; bus.hprot = 4'd0; bus.htrans = 2'b00; bus.hmastlock = 1'b0;
    bus.hwdata = '0;

    add("rd0",      1'b0, 3'd2, 32'h00,  32'h0,        1'b0, 1'b1, 32'h00000000);
    add("rd3c",     1'b0, 3'd2, 32'h3C,  32'h0,        1'b0, 1'b1, 32'h00000000);
    add("wr4",      1'b1, 3'd2, 32'h04,  32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    add("rd4",      1'b0, 3'd2, 32'h04,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF);
    add("wr8",      1'b1, 3'd2, 32'h08,  32'h11223344, 1'b0, 1'b0, 32'h0);
    add("wrb9",     1'b1, 3'd0, 32'h09,  32'hA5A5A5A5, 1'b0, 1'b0, 32'h0);
    add("rd8",      1'b0, 3'd2, 32'h08,  32'h0,        1'b0, 1'b1, 32'h1122A544);
    add("wrh12",    1'b1, 3'd1, 32'h12,  32'hBEEF1234, 1'b0, 1'b0, 32'h0);
    add("rd10",     1'b0, 3'd2, 32'h10,  32'h0,        1'b0, 1'b1, 32'hBEEF0000);
    add("err_mis",  1'b0, 3'd2, 32'h02,  32'h0,        1'b1, 1'b1, 32'hBEEF0000);
    add("err_rng",  1'b1, 3'd2, 32'h100, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hBEEF0000);
    add("rd0b",     1'b0, 3'd2, 32'h00,  32'h0,        1'b0, 1'b1, 32'h00000000);
    add("err_sz3",  1'b1, 3'd3, 32'h04,  32'h0,        1'b1, 1'b0, 32'h0);
    add("err_half", 1'b1, 3'd1, 32'h05,  32'h0,        1'b1, 1'b0, 32'h0);
    add("wrbb",     1'b1, 3'd0, 32'h0B,  32'h77000000, 1'b0, 1'b0, 32'h0);
    add("rdb8",     1'b0, 3'd0, 32'h08,  32'h0,        1'b0, 1'b1, 32'h7722A544);
    add("rd4b",     1'b0, 3'd2, 32'h04,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF);
    add("wrh0",     1'b1, 3'd1, 32'h00,  32'h0000C0DE, 1'b0, 1'b0, 32'h0);
    add("rdh2",     1'b0, 3'd1, 32'h02,  32'h0,        1'b0, 1'b1, 32'h0000C0DE);

    // Reset state
    repeat (2) @(posedge hclk);
    #1;
    chk("rst_ready", 32'(bus.hreadyout), 32'd1);
    chk("rst_resp",  32'(bus.hresp),     32'd0);
    chk("rst_rdata", bus.hrdata,         32'h0);
    hreset = 1'b0;

    foreach (vecs[i]) begin
      issue(vecs[i].name, vecs[i].wr, vecs[i].sz, vecs[i].addr);
      data_phase(vecs[i].name, vecs[i].wdata, vecs[i].err, vecs[i].chk, vecs[i].rdata);
    end

    // Pipelined write then read of the same word: read must see the committing data
    issue("b2b_wr", 1'b1, 3'd2, 32'h0C);
    bus.hwdata = 32'hCAFEF00D;
    issue("b2b_rd", 1'b0, 3'd2, 32'h0C);
    data_phase("b2b_rd", 32'h0, 1'b0, 1'b1, 32'hCAFEF00D);

    // Pipelined write then read of a different word: no false forwarding
    issue("b2b2_wr", 1'b1, 3'd2, 32'h14);
    bus.hwdata = 32'h01020304;
    issue("b2b2_rd", 1'b0, 3'd2, 32'h0C);
    data_phase("b2b2_rd", 32'h0, 1'b0, 1'b1, 32'hCAFEF00D);
    issue("rd14", 1'b0, 3'd2, 32'h14);
    data_phase("rd14", 32'h0, 1'b0, 1'b1, 32'h01020304);

    // Reset during an outstanding write data phase aborts it and clears memory
    issue("rst_wr", 1'b1, 3'd2, 32'h0C);
    idle_bus();
    bus.hwdata = 32'h55555555;
    hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0;
    chk("midrst_ready", 32'(bus.hreadyout), 32'd1);
    chk("midrst_resp",  32'(bus.hresp),     32'd0);
    chk("midrst_rdata", bus.hrdata,         32'h0);
    issue("rd_after_rst", 1'b0, 3'd2, 32'h0C);
    data_phase("rd_after_rst", 32'h0, 1'b0, 1'b1, 32'h00000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
